// File: rtl/adc128s_model.sv
`default_nettype none
// ============================================================================
// Module      : adc128s_model
// Description : Behavioural-but-synthesizable model of an 8-channel 12-bit
//               SPI ADC (ADC128S-style). The SPI pins are oversampled by the
//               system clock. A 16-bit command shifted in on MOSI selects
//               the channel whose value is returned in the *next* frame.
//               Each frame returns {4'h0, value} on MISO, MSB first.
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   rst_n        in   asynchronous active-low reset
//   SS_n         in   SPI slave select (active low), one frame per assertion
//   SCLK         in   SPI clock, mode 0 (idle low)
//   MOSI         in   command bits from master, MSB first
//   MISO         out  result bits to master, MSB first; Z while deselected
//   ld_cell_lft  in   channel 0 value
//   ld_cell_rght in   channel 4 value
//   steerPot     in   channel 5 value
//   batt         in   channel 6 value
//
// Revision    : 1.0 - initial release
// ============================================================================
module adc128s_model #(
    parameter logic [2:0] RST_CHNL = 3'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        SS_n,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [11:0] ld_cell_lft,
    input  logic [11:0] ld_cell_rght,
    input  logic [11:0] steerPot,
    input  logic [11:0] batt
);

    localparam logic [4:0] CNT_FULL = 5'd16;
    localparam logic [4:0] CNT_MAX  = 5'd31;

    // ------------------------------------------------------------------------
    // Synchronizers: two metastability stages plus one history stage.
    // Edge detection compares stage 2 (newest settled) with stage 3 (history).
    // MOSI gets the same two-stage delay so that, on a detected SCLK rise,
    // mosi_ff2 holds the bit that was on the pin around that SCLK edge.
    // ------------------------------------------------------------------------
    logic ss_ff1, ss_ff2, ss_ff3;
    logic sclk_ff1, sclk_ff2, sclk_ff3;
    logic mosi_ff1, mosi_ff2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_ff1   <= 1'b1;
            ss_ff2   <= 1'b1;
            ss_ff3   <= 1'b1;
            sclk_ff1 <= 1'b0;
            sclk_ff2 <= 1'b0;
            sclk_ff3 <= 1'b0;
            mosi_ff1 <= 1'b0;
            mosi_ff2 <= 1'b0;
        end else begin
            ss_ff1   <= SS_n;
            ss_ff2   <= ss_ff1;
            ss_ff3   <= ss_ff2;
            sclk_ff1 <= SCLK;
            sclk_ff2 <= sclk_ff1;
            sclk_ff3 <= sclk_ff2;
            mosi_ff1 <= MOSI;
            mosi_ff2 <= mosi_ff1;
        end
    end

    logic ss_fall, ss_rise, ss_active;
    logic sclk_rise, sclk_fall;

    assign ss_fall   =  ss_ff3 & ~ss_ff2;
    assign ss_rise   = ~ss_ff3 &  ss_ff2;
    // ss_ff3 is the stage that goes low on the same clk the TX register is
    // loaded, so MISO never shows stale TX contents at the start of a frame.
    // Because reset forces it high, MISO floats the instant rst_n drops.
    assign ss_active = ~ss_ff3;
    assign sclk_rise = ~sclk_ff3 &  sclk_ff2;
    assign sclk_fall =  sclk_ff3 & ~sclk_ff2;

    // ------------------------------------------------------------------------
    // Channel register and analog input select
    // ------------------------------------------------------------------------
    logic [2:0]  chnl;
    logic [11:0] sel_val;

    always_comb begin
        sel_val = 12'h000;
        unique case (chnl)
            3'd0:    sel_val = ld_cell_lft;
            3'd4:    sel_val = ld_cell_rght;
            3'd5:    sel_val = steerPot;
            3'd6:    sel_val = batt;
            default: sel_val = 12'h000;   // unconnected channels read zero
        endcase
    end

    // ------------------------------------------------------------------------
    // Edge counter: cleared at frame start, counts SCLK rises, saturates so
    // an over-long frame can never wrap back to exactly 16.
    // ------------------------------------------------------------------------
    logic [4:0] edge_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            edge_cnt <= 5'd0;
        end else if (ss_fall) begin
            edge_cnt <= 5'd0;
        end else if (ss_active && sclk_rise && (edge_cnt != CNT_MAX)) begin
            edge_cnt <= edge_cnt + 5'd1;
        end
    end

    // ------------------------------------------------------------------------
    // RX shift register: MOSI sampled on SCLK rise, LSB in.
    // ------------------------------------------------------------------------
    logic [15:0] rx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx <= 16'h0000;
        end else if (ss_active && sclk_rise) begin
            rx <= {rx[14:0], mosi_ff2};
        end
    end

    // ------------------------------------------------------------------------
    // TX shift register: the selected input is captured once at frame start,
    // so later input changes cannot corrupt the frame in progress. It shifts
    // on SCLK fall (mode 0: master samples on the following rise).
    // ------------------------------------------------------------------------
    logic [15:0] tx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx <= 16'h0000;
        end else if (ss_fall) begin
            tx <= {4'h0, sel_val};
        end else if (ss_active && sclk_fall) begin
            tx <= {tx[14:0], 1'b0};
        end
    end

    // ------------------------------------------------------------------------
    // Channel update at frame end. Only a well-formed 16-bit frame takes
    // effect; short or long frames leave the previous selection in place,
    // which gives the one-frame command/response pipeline.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chnl <= RST_CHNL;
        end else if (ss_rise && (edge_cnt == CNT_FULL)) begin
            chnl <= rx[13:11];
        end
    end

    assign MISO = ss_active ? tx[15] : 1'bz;

endmodule
`default_nettype wire

// File: tb/tb_adc128s_model.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc128s_model
// Description : Self-checking bench for adc128s_model. Directed frames cover
//               the documented scenarios; a randomized phase runs frames of
//               random command, length and input data against a frame-level
//               reference model (channel state + value lookup). MISO is
//               observed through a pull-up so a floating output reads as 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc128s_model;

    logic        clk;
    logic        rst_n;
    logic        SS_n;
    logic        SCLK;
    logic        MOSI;
    wire         miso_w;
    logic [11:0] ld_cell_lft;
    logic [11:0] ld_cell_rght;
    logic [11:0] steerPot;
    logic [11:0] batt;

    pullup (miso_w);

    adc128s_model #(.RST_CHNL(3'd0)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .SS_n         (SS_n),
        .SCLK         (SCLK),
        .MOSI         (MOSI),
        .MISO         (miso_w),
        .ld_cell_lft  (ld_cell_lft),
        .ld_cell_rght (ld_cell_rght),
        .steerPot     (steerPot),
        .batt         (batt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // reference model state
    int          m_chnl;
    // one-shot mid-frame change of steerPot
    logic        mid_en;
    logic [11:0] mid_val;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] chan_val(input int ch);
        case (ch)
            0:       return ld_cell_lft;
            4:       return ld_cell_rght;
            5:       return steerPot;
            6:       return batt;
            default: return 12'h000;
        endcase
    endfunction

    // Runs one frame of nbits SCLK pulses (1..32). resp collects the MISO
    // bits sampled just before each rise; exp is the model's prediction:
    // the 16-bit result word followed by zeros, truncated to nbits.
    task automatic spi_frame(input logic [15:0] cmd, input int nbits,
                             output logic [31:0] resp, output logic [31:0] exp);
        logic [31:0] stream;
        stream = {4'h0, chan_val(m_chnl), 16'h0000};
        exp    = stream >> (32 - nbits);
        resp   = 32'h0;
        SS_n   = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            MOSI = (i < 16) ? cmd[15 - i] : 1'b0;
            repeat (5) @(negedge clk);
            resp = {resp[30:0], miso_w};
            if (mid_en && i == 8) begin
                steerPot = mid_val;
                mid_en   = 1'b0;
            end
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (8) @(negedge clk);
        if (nbits == 16) m_chnl = int'(cmd[13:11]);
    endtask

    task automatic sclk_idle(input int n);
        for (int i = 0; i < n; i++) begin
            SCLK = 1'b1;
            MOSI = 1'($urandom_range(0, 1));
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
            repeat (5) @(negedge clk);
        end
    endtask

    // Starts a frame, clocks two bits, then resets while SS_n is still low.
    task automatic reset_mid_frame();
        SS_n = 1'b0;
        repeat (6) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            MOSI = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b1;
            repeat (5) @(negedge clk);
            SCLK = 1'b0;
        end
        repeat (5) @(negedge clk);
        check("miso_before_rst", {31'h0, miso_w}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("miso_hiz_on_rst", {31'h0, miso_w}, 32'h1);
        SS_n = 1'b1;
        MOSI = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("miso_hiz_after_rst", {31'h0, miso_w}, 32'h1);
        m_chnl = 0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] r, e;
        logic [15:0] cmd;
        int          n;

        rst_n        = 1'b0;
        SS_n         = 1'b1;
        SCLK         = 1'b0;
        MOSI         = 1'b0;
        mid_en       = 1'b0;
        mid_val      = 12'h000;
        ld_cell_lft  = 12'h400;
        ld_cell_rght = 12'h000;
        steerPot     = 12'h000;
        batt         = 12'h000;
        m_chnl       = 0;
        repeat (3) @(negedge clk);
        check("miso_hiz_in_reset", {31'h0, miso_w}, 32'h1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("miso_hiz_idle", {31'h0, miso_w}, 32'h1);

        // reset channel -> ld_cell_lft
        spi_frame(16'h0000, 16, r, e);
        check("rst_chnl_frame", r, 32'h0400);

        // command channel 6, read it back next frame, then channel 0 again
        batt = 12'h8FF;
        spi_frame(16'h3000, 16, r, e);
        check("cmd6_frame", r, 32'h0400);
        spi_frame(16'h0000, 16, r, e);
        check("batt_result", r, 32'h08FF);
        spi_frame(16'h0000, 16, r, e);
        check("chnl0_after_batt", r, 32'h0400);
        check("miso_hiz_between", {31'h0, miso_w}, 32'h1);

        // input change mid-frame must not affect the frame in progress
        steerPot = 12'h123;
        spi_frame(16'h2800, 16, r, e);
        mid_en  = 1'b1;
        mid_val = 12'hABC;
        spi_frame(16'h0000, 16, r, e);
        check("steer_midchange", r, 32'h0123);

        // unconnected channel returns zero
        spi_frame(16'h0800, 16, r, e);
        spi_frame(16'h0000, 16, r, e);
        check("chnl1_zero", r, 32'h0000);

        // aborted frame does not change channel
        ld_cell_rght = 12'hFFF;
        spi_frame(16'h2000, 8, r, e);
        check("short_frame_bits", r, 32'h04);
        spi_frame(16'h0000, 16, r, e);
        check("after_short_frame", r, 32'h0400);
        spi_frame(16'h2000, 16, r, e);
        spi_frame(16'h0000, 16, r, e);
        check("rght_result", r, 32'h0FFF);

        // over-long frame: zeros shifted after the word, channel unchanged
        spi_frame(16'h2000, 20, r, e);
        check("long_frame_bits", r, 32'h04000);
        spi_frame(16'h0000, 16, r, e);
        check("after_long_frame", r, 32'h0400);

        // SCLK activity while deselected is ignored
        spi_frame(16'h3000, 16, r, e);
        sclk_idle(20);
        spi_frame(16'h0000, 16, r, e);
        check("idle_sclk_ignored", r, 32'h08FF);

        // reset mid-frame after selecting channel 4
        spi_frame(16'h2000, 16, r, e);
        reset_mid_frame();
        spi_frame(16'h0000, 16, r, e);
        check("after_mid_rst", r, 32'h0400);

        // randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            ld_cell_lft  = 12'($urandom);
            ld_cell_rght = 12'($urandom);
            steerPot     = 12'($urandom);
            batt         = 12'($urandom);
            cmd          = 16'($urandom);
            case ($urandom_range(0, 9))
                0:       n = $urandom_range(1, 15);
                1:       n = $urandom_range(17, 24);
                default: n = 16;
            endcase
            if ($urandom_range(0, 3) == 0) sclk_idle($urandom_range(1, 4));
            spi_frame(cmd, n, r, e);
            check($sformatf("rand%0d_n%0d", k, n), r, e);
        end
        check("miso_hiz_end", {31'h0, miso_w}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
